// File: rtl/fetch_unit_l3_if.sv
// ============================================================================
// Module   : fetch_unit_l3_if
// Brief    : Bundle of the fetch unit's memory request/response channels, the
//            decode-side instruction channel and the squash notification.
//            master = fetch unit side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_unit_l3_if #(
  parameter int p_seq_num_bits = 5
);
  // instruction memory request channel
  logic                      mem_req_val;
  logic                      mem_req_rdy;
  logic [31:0]               mem_req_addr;
  // instruction memory response channel (in-order)
  logic                      mem_resp_val;
  logic                      mem_resp_rdy;
  logic [31:0]               mem_resp_data;
  // decode channel
  logic                      d_val;
  logic                      d_rdy;
  logic [31:0]               d_inst;
  logic [31:0]               d_pc;
  logic [p_seq_num_bits-1:0] d_seq_num;
  // squash notification
  logic                      squash_val;
  logic [31:0]               squash_target;
  logic [p_seq_num_bits-1:0] squash_seq_num;

  modport master (
    output mem_req_val, mem_req_addr,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_data,
    output mem_resp_rdy,
    output d_val, d_inst, d_pc, d_seq_num,
    input  d_rdy,
    input  squash_val, squash_target, squash_seq_num
  );

  modport slave (
    input  mem_req_val, mem_req_addr,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_data,
    input  mem_resp_rdy,
    input  d_val, d_inst, d_pc, d_seq_num,
    output d_rdy,
    output squash_val, squash_target, squash_seq_num
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit_l3.sv
// ============================================================================
// Module   : fetch_unit_l3
// Brief    : Instruction fetch unit. Issues sequential fetches, tracks the PC of
//            every outstanding request, buffers responses for decode, numbers
//            instructions and drops responses to requests killed by a squash.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit_l3 #(
  parameter int          p_seq_num_bits  = 5,
  parameter logic [31:0] p_rst_addr      = 32'h200,
  parameter int          p_max_in_flight = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_l3_if.master bus
);

  localparam int c_ptr_w = $clog2(p_max_in_flight);
  localparam int c_cnt_w = $clog2(p_max_in_flight + 1);

  // fetch PC, sequence counter, occupancy and drop accounting
  logic [31:0]               r_fetch_pc;
  logic [p_seq_num_bits-1:0] r_seq;
  logic [c_cnt_w-1:0]        r_occ;
  logic [c_cnt_w-1:0]        r_drop;

  // PC FIFO: address of every request still awaiting its response
  logic [31:0]               r_pcf_mem [p_max_in_flight];
  logic [c_ptr_w-1:0]        r_pcf_wr;
  logic [c_ptr_w-1:0]        r_pcf_rd;
  logic [c_cnt_w-1:0]        r_pcf_cnt;

  // response buffer: {inst, pc} entries waiting for decode
  logic [31:0]               r_rb_inst [p_max_in_flight];
  logic [31:0]               r_rb_pc   [p_max_in_flight];
  logic [c_ptr_w-1:0]        r_rb_wr;
  logic [c_ptr_w-1:0]        r_rb_rd;
  logic [c_cnt_w-1:0]        r_rb_cnt;

  logic                      w_req_fire;
  logic                      w_resp_fire;
  logic                      w_d_fire;
  logic                      w_drop_resp;
  logic                      w_rb_push;
  logic [c_cnt_w-1:0]        w_drop_on_squash;

  // handshakes; the buffer always has room because occupancy gates requests
  assign bus.mem_req_val  = !rst && !bus.squash_val && (r_occ < c_cnt_w'(p_max_in_flight));
  assign bus.mem_req_addr = r_fetch_pc;
  assign bus.mem_resp_rdy = 1'b1;
  assign bus.d_val        = (r_rb_cnt != '0) && !bus.squash_val;
  assign bus.d_inst       = r_rb_inst[r_rb_rd];
  assign bus.d_pc         = r_rb_pc[r_rb_rd];
  assign bus.d_seq_num    = r_seq;

  assign w_req_fire  = bus.mem_req_val && bus.mem_req_rdy;
  assign w_resp_fire = bus.mem_resp_val && bus.mem_resp_rdy;
  assign w_d_fire    = bus.d_val && bus.d_rdy;
  assign w_drop_resp = w_resp_fire && (r_drop != '0);
  assign w_rb_push   = w_resp_fire && !w_drop_resp && !bus.squash_val;

  // a response firing in the squash cycle is itself discarded, so it is not
  // counted among the responses still to be dropped
  assign w_drop_on_squash = r_pcf_cnt - c_cnt_w'(w_resp_fire);

  // fetch PC: redirect on squash, otherwise step past each issued request
  always_ff @(posedge clk) begin
    if (rst)                 r_fetch_pc <= p_rst_addr;
    else if (bus.squash_val) r_fetch_pc <= bus.squash_target;
    else if (w_req_fire)     r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  // sequence counter: restarts after the squashing instruction, counts transfers
  always_ff @(posedge clk) begin
    if (rst)                 r_seq <= '0;
    else if (bus.squash_val) r_seq <= bus.squash_seq_num + p_seq_num_bits'(1);
    else if (w_d_fire)       r_seq <= r_seq + p_seq_num_bits'(1);
  end

  // occupancy and drop counter; a kept response only moves an entry from
  // outstanding to buffered, so it leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ  <= '0;
      r_drop <= '0;
    end else if (bus.squash_val) begin
      r_occ  <= w_drop_on_squash;
      r_drop <= w_drop_on_squash;
    end else begin
      r_occ <= r_occ + c_cnt_w'(w_req_fire) - c_cnt_w'(w_d_fire) - c_cnt_w'(w_drop_resp);
      if (w_drop_resp) r_drop <= r_drop - c_cnt_w'(1);
    end
  end

  // PC FIFO: push on request, pop on every response (kept or dropped)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf_wr  <= '0;
      r_pcf_rd  <= '0;
      r_pcf_cnt <= '0;
    end else begin
      if (w_req_fire) begin
        r_pcf_mem[r_pcf_wr] <= r_fetch_pc;
        r_pcf_wr            <= r_pcf_wr + c_ptr_w'(1);
      end
      if (w_resp_fire) r_pcf_rd <= r_pcf_rd + c_ptr_w'(1);
      r_pcf_cnt <= r_pcf_cnt + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp_fire);
    end
  end

  // response buffer: flushed on squash, filled by kept responses, drained by decode
  always_ff @(posedge clk) begin
    if (rst || bus.squash_val) begin
      r_rb_wr  <= '0;
      r_rb_rd  <= '0;
      r_rb_cnt <= '0;
    end else begin
      if (w_rb_push) begin
        r_rb_inst[r_rb_wr] <= bus.mem_resp_data;
        r_rb_pc[r_rb_wr]   <= r_pcf_mem[r_pcf_rd];
        r_rb_wr            <= r_rb_wr + c_ptr_w'(1);
      end
      if (w_d_fire) r_rb_rd <= r_rb_rd + c_ptr_w'(1);
      r_rb_cnt <= r_rb_cnt + c_cnt_w'(w_rb_push) - c_cnt_w'(w_d_fire);
    end
  end

  // a response with nothing outstanding means the memory broke the protocol
  a_resp_without_request : assert property (
    @(posedge clk) disable iff (rst) w_resp_fire |-> (r_pcf_cnt != '0)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_l3.sv
// ============================================================================
// Module   : tb_fetch_unit_l3
// Brief    : Self-checking bench for fetch_unit_l3 with an in-order memory
//            model and a scoreboard of instructions expected on decode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit_l3;

  localparam int          SEQ_W    = 5;
  localparam int          MAXF     = 2;
  localparam logic [31:0] RST_ADDR = 32'h200;
  localparam logic [31:0] DATA_KEY = 32'h5A5A_C3C3;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          ready;
  } pend_t;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_l3_if #(.p_seq_num_bits(SEQ_W)) bus ();

  fetch_unit_l3 #(
    .p_seq_num_bits (SEQ_W),
    .p_rst_addr     (RST_ADDR),
    .p_max_in_flight(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pend_t            pend_q[$];
  exp_t             exp_q[$];
  logic [31:0]      m_pc;
  logic [SEQ_W-1:0] m_seq;
  int               cycle;
  bit               resp_en;
  int               extra_lat_max;
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cycle);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    m_pc  = RST_ADDR;
    m_seq = '0;
  endtask

  // one clock cycle: check and update the model at negedge, drive memory after posedge
  task automatic tick();
    bit    req_f, resp_f, d_f, exp_req_val, exp_d_val;
    int    occ;
    pend_t p;
    exp_t  e;
    @(negedge clk);
    if (rst) begin
      check("rst_req_val", 32'(bus.mem_req_val), 32'd0);
      check("rst_d_val", 32'(bus.d_val), 32'd0);
    end else begin
      occ         = pend_q.size() + exp_q.size();
      exp_req_val = !bus.squash_val && (occ < MAXF);
      exp_d_val   = (exp_q.size() > 0) && !bus.squash_val;
      check("req_val", 32'(bus.mem_req_val), 32'(exp_req_val));
      if (exp_req_val) check("req_addr", bus.mem_req_addr, m_pc);
      check("resp_rdy", 32'(bus.mem_resp_rdy), 32'd1);
      check("d_val", 32'(bus.d_val), 32'(exp_d_val));
      if (exp_d_val) begin
        check("d_pc", bus.d_pc, exp_q[0].pc);
        check("d_inst", bus.d_inst, exp_q[0].inst);
        check("d_seq", 32'(bus.d_seq_num), 32'(exp_q[0].seq));
      end
      req_f  = bus.mem_req_val && bus.mem_req_rdy;
      resp_f = bus.mem_resp_val && bus.mem_resp_rdy;
      d_f    = bus.d_val && bus.d_rdy;
      if (d_f && exp_q.size() > 0) void'(exp_q.pop_front());
      if (req_f) begin
        p.addr  = bus.mem_req_addr;
        p.stale = 1'b0;
        p.ready = cycle + 1 + $urandom_range(0, extra_lat_max);
        pend_q.push_back(p);
        m_pc = m_pc + 32'd4;
      end
      if (resp_f && pend_q.size() > 0) begin
        p = pend_q.pop_front();
        if (!p.stale && !bus.squash_val) begin
          e.pc   = p.addr;
          e.inst = p.addr ^ DATA_KEY;
          e.seq  = m_seq;
          exp_q.push_back(e);
          m_seq = m_seq + 1'b1;
        end
      end
      if (bus.squash_val) begin
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        exp_q.delete();
        m_seq = bus.squash_seq_num + 1'b1;
        m_pc  = bus.squash_target;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (!rst && resp_en && pend_q.size() > 0 && pend_q[0].ready <= cycle) begin
      bus.mem_resp_val  = 1'b1;
      bus.mem_resp_data = pend_q[0].addr ^ DATA_KEY;
    end else begin
      bus.mem_resp_val  = 1'b0;
      bus.mem_resp_data = $urandom();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic squash(input logic [31:0] target, input logic [SEQ_W-1:0] seq);
    bus.squash_val     = 1'b1;
    bus.squash_target  = target;
    bus.squash_seq_num = seq;
    tick();
    bus.squash_val = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    bus.squash_val = 1'b0;
    bus.mem_resp_val = 1'b0;
    model_reset();
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    cycle              = 0;
    resp_en            = 1'b1;
    extra_lat_max      = 0;
    bus.mem_req_rdy    = 1'b1;
    bus.mem_resp_val   = 1'b0;
    bus.mem_resp_data  = '0;
    bus.d_rdy          = 1'b0;
    bus.squash_val     = 1'b0;
    bus.squash_target  = '0;
    bus.squash_seq_num = '0;
    model_reset();
    @(posedge clk);
    #1;

    // reset, then fill two entries with decode stalled; requests must stop
    do_reset(3);
    run(8);

    // release decode: 0x200 seq 0, 0x204 seq 1, then streaming
    bus.d_rdy = 1'b1;
    run(10);

    // two outstanding requests killed by a squash to 0x1000 with seq 3
    resp_en = 1'b0;
    run(3);
    squash(32'h1000, 5'd3);
    resp_en = 1'b1;
    run(10);

    // squash while a response fires with one outstanding; seq 31 wraps to 0
    squash(32'h1000, 5'd31);
    run(10);

    // memory refuses requests for five cycles: request held steady
    bus.mem_req_rdy = 1'b0;
    run(5);
    bus.mem_req_rdy = 1'b1;
    run(6);

    // randomised traffic with variable latency and occasional squashes
    extra_lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      bus.mem_req_rdy = ($urandom_range(0, 3) != 0);
      bus.d_rdy       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        bus.squash_val     = 1'b1;
        bus.squash_target  = $urandom() & 32'hFFFF_FFFC;
        bus.squash_seq_num = SEQ_W'($urandom());
      end else begin
        bus.squash_val = 1'b0;
      end
      tick();
    end
    bus.squash_val = 1'b0;

    // reset mid-operation, then restart from the reset address
    bus.mem_req_rdy = 1'b1;
    bus.d_rdy       = 1'b1;
    extra_lat_max   = 0;
    do_reset(2);
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
